// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: computes a - b - bin one bit per clock with a
// single full-subtractor cell, a registered borrow and a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;
  logic             a0, b0, d, br_nxt;
  logic             load, last;

  // Full-subtractor cell on the LSBs of the operand shift registers.
  always_comb begin
    a0      = a_sr[0];
    b0      = b_sr[0];
    d       = a0 ^ b0 ^ br;
    br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nxt = {d, res_sr[WIDTH-1:1]};
    last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
    busy    = (state == RUN);
    done    = (state == DONE);
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        load      = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      br     <= br_nxt;
      cnt    <= cnt + CW'(1);
      // Visible results move only on the edge that processes the MSB.
      if (last) begin
        diff     <= res_nxt;
        borrow   <= br_nxt;
        overflow <= (a_msb != b_msb) & (d != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed,
// reset and back-to-back cases and a 4-bit instance for an exhaustive sweep.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic       clk, rst_n;
  logic       start8, bin8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  exp_t q8[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt8 = 0;
  int   busy_cnt4 = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: w-bit a - b - bin evaluated with one extra bit of headroom.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
    logic [32:0] full, mask;
    exp_t        e;
    full     = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    mask     = (33'd1 << w) - 33'd1;
    e.diff   = 32'(full & mask);
    e.borrow = full[w];
    e.ovf    = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
    return e;
  endfunction

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt8 = 0;
    else begin
      if (busy8) busy_cnt8++;
      if (done8) begin
        check("busy8_cycles", busy_cnt8, 8);
        check("busy8_in_done", {31'd0, busy8}, 0);
        busy_cnt8 = 0;
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done8: got done=1, expected no pending result (t=%0t)", $time);
        end else begin
          e = q8.pop_front();
          check("diff8", {24'd0, diff8}, e.diff);
          check("borrow8", {31'd0, borrow8}, {31'd0, e.borrow});
          check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_cnt4 = 0;
    else begin
      if (busy4) busy_cnt4++;
      if (done4) begin
        check("busy4_cycles", busy_cnt4, 4);
        busy_cnt4 = 0;
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done4: got done=1, expected no pending result (t=%0t)", $time);
        end else begin
          e = q4.pop_front();
          check("diff4", {28'd0, diff4}, e.diff);
          check("borrow4", {31'd0, borrow4}, {31'd0, e.borrow});
          check("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic wait_done(input bit w4, input string name);
    int n = 0;
    while (!(w4 ? done4 : done8) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 30 cycles, expected done", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; returns once it is idle again.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.diff   = {24'd0, ed};
    e.borrow = eb;
    e.ovf    = eo;
    q8.push_back(e);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done(1'b0, "op8");
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    q4.push_back(model(4, {28'd0, a}, {28'd0, b}, bin));
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    wait_done(1'b1, "op4");
  endtask

  logic [7:0] bb_a [4] = '{8'h12, 8'h00, 8'hA5, 8'h7F};
  logic [7:0] bb_b [4] = '{8'h34, 8'h00, 8'h5A, 8'h80};
  logic       bb_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_diff", {24'd0, diff8}, 0);
    check("rst_borrow", {31'd0, borrow8}, 0);
    check("rst_ovf", {31'd0, ovf8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    op8(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0);

    // Operands scrambled during RUN plus a mid-RUN start: one result, unchanged.
    begin
      exp_t e;
      e.diff = 32'h01; e.borrow = 1'b0; e.ovf = 1'b0;
      q8.push_back(e);
      a8 = 8'h05; b8 = 8'h03; bin8 = 1'b1; start8 = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
        start8 = (i == 3);
        @(posedge clk);
        #1;
      end
      start8 = 1'b0;
    end

    // Reset four cycles into an operation aborts it with no done.
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_done", {31'd0, done8}, 0);
    check("abort_diff", {24'd0, diff8}, 0);
    check("abort_borrow", {31'd0, borrow8}, 0);
    check("abort_ovf", {31'd0, ovf8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

    // Back-to-back: start held high, new operands loaded in each DONE cycle.
    for (int i = 0; i < 4; i++) begin
      a8 = bb_a[i]; b8 = bb_b[i]; bin8 = bb_c[i]; start8 = 1'b1;
      q8.push_back(model(8, {24'd0, bb_a[i]}, {24'd0, bb_b[i]}, bb_c[i]));
      @(posedge clk);
      #1;
      repeat (8) @(posedge clk);
      #1;
    end
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));

    repeat (15) @(posedge clk);
    #1;
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
